// File: rtl/tt_sweep_pkg.sv
// tt_sweep_pkg: shared types and constants for the truth-table sweep checker.
//   state_t         - checker FSM states (IDLE, HOLD, FIN)
//   num_vectors(n)  - number of input combinations for an n-input circuit
//   *_MIN / *_MAX   - legal ranges for N_IN and HOLD_CYCLES
//   HOLD_CNT_W      - width of the hold timer, sized for HOLD_CYCLES_MAX
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int N_IN_MIN        = 1;
  localparam int N_IN_MAX        = 8;
  localparam int HOLD_CYCLES_MIN = 1;
  localparam int HOLD_CYCLES_MAX = 255;
  localparam int HOLD_CNT_W      = 8;

  function automatic int num_vectors(input int n);
    return 1 << n;
  endfunction

endpackage

// File: rtl/tt_hold_timer.sv
// tt_hold_timer: down-counter that measures how long each vector is held.
//   clk, rst : clock, asynchronous active-high reset (count clears to 0)
//   load     : reload with HOLD_CYCLES-1 (start of a vector)
//   en       : count down while enabled, saturating at 0
//   tc       : terminal count, high while the count is 0 (last hold cycle)
module tt_hold_timer
  import tt_sweep_pkg::*;
#(
  parameter int HOLD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic tc
);

  localparam logic [HOLD_CNT_W-1:0] LOAD_VAL = HOLD_CNT_W'(HOLD_CYCLES - 1);
  localparam logic [HOLD_CNT_W-1:0] CNT_ONE  = HOLD_CNT_W'(1);

  logic [HOLD_CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CNT_ONE;
    end
  end

  // With HOLD_CYCLES=1 the load value is 0, so tc is high on every hold edge.
  assign tc = (cnt == '0);

endmodule

// File: rtl/tt_sweep_checker.sv
// tt_sweep_checker: sweeps every input combination of an N_IN-input
// combinational circuit, holds each for HOLD_CYCLES clocks, samples dut_y on
// the last hold cycle and compares it with a latched minterm mask.
//   clk, rst   : clock, asynchronous active-high reset
//   start      : begin a sweep (only honoured in IDLE)
//   tt_mask    : expected truth table, bit i = expected Y for stim == i
//   dut_y      : output of the circuit under test
//   stim       : current input vector (stim[N_IN-1] is the MSB input)
//   busy       : sweep in progress
//   done       : one-cycle pulse at the end of a sweep
//   pass       : err_count == 0, valid from done until the next start
//   err_count  : mismatching vectors in the last sweep
//   captured   : observed Y per vector
//   state_dbg  : current FSM state
// Build option: define TT_SWEEP_STOP_ON_ERR_EN to end the sweep on the
// first mismatch (stim freezes at the failing vector).
//
// Handshake: start is a level sampled on a rising edge while IDLE; one accept
// per sweep. done is a single-cycle strobe; pass/err_count/captured/stim stay
// stable from done until the next accepted start.
module tt_sweep_checker
  import tt_sweep_pkg::*;
#(
  parameter  int N_IN        = 3,
  parameter  int HOLD_CYCLES = 4,
  localparam int NV          = num_vectors(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NV-1:0]   tt_mask,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [NV-1:0]   captured,
  output state_t          state_dbg
);

  if (N_IN < N_IN_MIN || N_IN > N_IN_MAX) begin : g_bad_n_in
    $error("tt_sweep_checker: N_IN out of range 1..8");
  end
  if (HOLD_CYCLES < HOLD_CYCLES_MIN || HOLD_CYCLES > HOLD_CYCLES_MAX) begin : g_bad_hold
    $error("tt_sweep_checker: HOLD_CYCLES out of range 1..255");
  end

  localparam logic [N_IN-1:0] LAST_VEC = '1;
  localparam logic [N_IN-1:0] STIM_ONE = N_IN'(1);
  localparam logic [N_IN:0]   ERR_ONE  = (N_IN + 1)'(1);

  state_t        state, state_nxt;
  logic [NV-1:0] mask_q;
  logic          tc;
  logic          last_vec, mismatch, stop_here;
  logic          accept, sample, advance, fin, timer_load, timer_en;

  assign last_vec = (stim == LAST_VEC);
  assign mismatch = (dut_y != mask_q[stim]);

`ifdef TT_SWEEP_STOP_ON_ERR_EN
  assign stop_here = last_vec || mismatch;
`else
  assign stop_here = last_vec;
`endif

  tt_hold_timer #(
    .HOLD_CYCLES(HOLD_CYCLES)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .load(timer_load),
    .en  (timer_en),
    .tc  (tc)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = HOLD;
      HOLD:    if (tc && stop_here) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control decode
  always_comb begin
    accept     = 1'b0;
    sample     = 1'b0;
    advance    = 1'b0;
    fin        = 1'b0;
    timer_load = 1'b0;
    timer_en   = 1'b0;
    case (state)
      IDLE: begin
        accept     = start;
        timer_load = start;
      end
      HOLD: begin
        timer_en   = 1'b1;
        sample     = tc;
        advance    = tc && !stop_here;
        timer_load = tc && !stop_here;
      end
      FIN:     fin = 1'b1;
      default: ;
    endcase
  end

  // Datapath: mask latch, stimulus, capture and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q    <= '0;
      stim      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      captured  <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        mask_q    <= tt_mask;
        stim      <= '0;
        busy      <= 1'b1;
        pass      <= 1'b0;
        err_count <= '0;
        captured  <= '0;
      end
      if (sample) begin
        captured[stim] <= dut_y;
        if (mismatch) err_count <= err_count + ERR_ONE;
      end
      if (advance) stim <= stim + STIM_ONE;
      // err_count already includes the last vector by the time FIN is reached.
      if (fin) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == '0);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_tt_sweep_checker.sv
module tb_tt_sweep_checker;

  typedef struct packed {
    int         cyc;
    logic       pass;
    logic [3:0] err;
    logic [7:0] cap;
    logic [2:0] stim;
  } exp_t;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance (defaults: N_IN=3, HOLD_CYCLES=4)
  logic        start1 = 1'b0;
  logic [7:0]  mask1  = 8'h00;
  logic        y1;
  logic [2:0]  stim1;
  logic        busy1, done1, pass1;
  logic [3:0]  err1;
  logic [7:0]  cap1;
  tt_sweep_pkg::state_t st1;
  int          dut_mode = 0;

  tt_sweep_checker u_dut (
    .clk(clk), .rst(rst), .start(start1), .tt_mask(mask1), .dut_y(y1),
    .stim(stim1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .captured(cap1), .state_dbg(st1)
  );

  // Circuit under test: Y = ABC + AB + AC, or tied low
  always_comb begin
    if (dut_mode == 0)
      y1 = (stim1[2] & stim1[1] & stim1[0]) | (stim1[2] & stim1[1]) | (stim1[2] & stim1[0]);
    else
      y1 = 1'b0;
  end

  // Second instance: N_IN=2, HOLD_CYCLES=1, XOR circuit
  logic        start2 = 1'b0;
  logic [3:0]  mask2  = 4'h0;
  logic        y2;
  logic [1:0]  stim2;
  logic        busy2, done2, pass2;
  logic [2:0]  err2;
  logic [3:0]  cap2;
  tt_sweep_pkg::state_t st2;

  tt_sweep_checker #(.N_IN(2), .HOLD_CYCLES(1)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .tt_mask(mask2), .dut_y(y2),
    .stim(stim2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .captured(cap2), .state_dbg(st2)
  );

  assign y2 = stim2[1] ^ stim2[0];

  // Scoreboard
  int   checks = 0;
  int   errors = 0;
  exp_t exp1_q[$];
  exp_t exp2_q[$];
  logic prev_done1 = 1'b0;
  logic prev_done2 = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon1
    exp_t e;
    if (prev_done1) check("u1_done_pulse_width", 32'(done1), 0);
    prev_done1 <= done1;
    if (done1) begin
      if (exp1_q.size() == 0) begin
        check("u1_unexpected_done", 1, 0);
      end else begin
        e = exp1_q.pop_front();
        check("u1_done_cycle", cyc, e.cyc);
        check("u1_pass", 32'(pass1), 32'(e.pass));
        check("u1_err_count", 32'(err1), 32'(e.err));
        check("u1_captured", 32'(cap1), 32'(e.cap));
        check("u1_stim", 32'(stim1), 32'(e.stim));
        check("u1_busy_at_done", 32'(busy1), 0);
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (prev_done2) check("u2_done_pulse_width", 32'(done2), 0);
    prev_done2 <= done2;
    if (done2) begin
      if (exp2_q.size() == 0) begin
        check("u2_unexpected_done", 1, 0);
      end else begin
        e = exp2_q.pop_front();
        check("u2_done_cycle", cyc, e.cyc);
        check("u2_pass", 32'(pass2), 32'(e.pass));
        check("u2_err_count", 32'(err2), 32'(e.err));
        check("u2_captured", 32'(cap2), 32'(e.cap));
        check("u2_stim", 32'(stim2), 32'(e.stim));
      end
    end
  end

  // Drivers: start is raised at a negedge so the next rising edge (k) accepts it
  task automatic issue1(input logic [7:0] mask, input int mode, input bit expect_done,
                        input int lat, input logic p, input logic [3:0] err,
                        input logic [7:0] cap, input logic [2:0] st);
    exp_t e;
    @(negedge clk);
    dut_mode = mode;
    mask1    = mask;
    start1   = 1'b1;
    if (expect_done) begin
      e.cyc = cyc + 1 + lat; e.pass = p; e.err = err; e.cap = cap; e.stim = st;
      exp1_q.push_back(e);
    end
    @(negedge clk);
    start1 = 1'b0;
  endtask

  task automatic issue2(input logic [3:0] mask, input int lat, input logic p,
                        input logic [3:0] err, input logic [7:0] cap, input logic [2:0] st);
    exp_t e;
    @(negedge clk);
    mask2  = mask;
    start2 = 1'b1;
    e.cyc = cyc + 1 + lat; e.pass = p; e.err = err; e.cap = cap; e.stim = st;
    exp2_q.push_back(e);
    @(negedge clk);
    start2 = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 100 && (exp1_q.size() != 0 || exp2_q.size() != 0); i++)
      @(negedge clk);
    check(name, 32'(exp1_q.size() + exp2_q.size()), 0);
    exp1_q.delete();
    exp2_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_stim", 32'(stim1), 0);
    check("rst_busy", 32'(busy1), 0);
    check("rst_done", 32'(done1), 0);
    check("rst_pass", 32'(pass1), 0);
    check("rst_err", 32'(err1), 0);
    check("rst_captured", 32'(cap1), 0);
    check("rst_state", 32'(st1), 32'(tt_sweep_pkg::IDLE));
    check("rst_u2_stim", 32'(stim2), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: A(B+C) against matching mask
    issue1(8'hE0, 0, 1, 33, 1'b1, 4'd0, 8'hE0, 3'd7);
    check("s1_busy_after_start", 32'(busy1), 1);
    check("s1_state_hold", 32'(st1), 32'(tt_sweep_pkg::HOLD));
    check("s1_stim_first", 32'(stim1), 0);
    wait_idle("s1_timeout");
    check("s1_pass_held", 32'(pass1), 1);
    check("s1_captured_held", 32'(cap1), 32'h E0);

    // 5: restart attempt at k+5 and mask change at k+6 are ignored
    issue1(8'hE0, 0, 1, 33, 1'b1, 4'd0, 8'hE0, 3'd7);
    repeat (4) @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    mask1  = 8'h00;
    wait_idle("s5_timeout");

    // 2: vector 3 expected high but circuit gives 0
`ifdef TT_SWEEP_STOP_ON_ERR_EN
    issue1(8'hE8, 0, 1, 17, 1'b0, 4'd1, 8'h00, 3'd3);
`else
    issue1(8'hE8, 0, 1, 33, 1'b0, 4'd1, 8'hE0, 3'd7);
`endif
    wait_idle("s2_timeout");

    // 3: Y tied low, every vector expected high
`ifdef TT_SWEEP_STOP_ON_ERR_EN
    issue1(8'hFF, 1, 1, 5, 1'b0, 4'd1, 8'h00, 3'd0);
`else
    issue1(8'hFF, 1, 1, 33, 1'b0, 4'd8, 8'h00, 3'd7);
`endif
    wait_idle("s3_timeout");

    // 4: reset mid-sweep, then a clean sweep
    issue1(8'hE0, 0, 0, 0, 1'b0, 4'd0, 8'h00, 3'd0);
    repeat (10) @(negedge clk);
    check("s4_busy_before_rst", 32'(busy1), 1);
    check("s4_stim_before_rst", 32'(stim1), 2);
    #1 rst = 1'b1;
    #1;
    check("s4_rst_stim", 32'(stim1), 0);
    check("s4_rst_busy", 32'(busy1), 0);
    check("s4_rst_done", 32'(done1), 0);
    check("s4_rst_pass", 32'(pass1), 0);
    check("s4_rst_err", 32'(err1), 0);
    check("s4_rst_captured", 32'(cap1), 0);
    check("s4_rst_state", 32'(st1), 32'(tt_sweep_pkg::IDLE));
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    issue1(8'hE0, 0, 1, 33, 1'b1, 4'd0, 8'hE0, 3'd7);
    wait_idle("s4_timeout");

    // 6: N_IN=2, HOLD_CYCLES=1, XOR
    issue2(4'h6, 5, 1'b1, 4'd0, 8'h06, 3'd3);
    wait_idle("s6_timeout");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tt_sweep_checker.md
Name: tt_sweep_checker

Overview:
- Sequential truth-table sweeper and checker for an N-input single-output combinational circuit, the kind built from gate primitives.
- On start it drives every input combination 0..2^N_IN-1 onto stim and holds each one for HOLD_CYCLES clocks.
- On the last hold cycle of each vector it samples dut_y and compares it with a programmable minterm mask.
- Sits beside a combinational DUT as an on-chip self-check; replaces hand-written stimulus lists.

Parameters:
- N_IN, 3, number of DUT inputs; legal range 1..8.
- HOLD_CYCLES, 4, clocks each vector is held, covering gate delays; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begins a sweep; sampled only in IDLE.
- tt_mask  input  2^N_IN  expected output; bit i = expected Y when stim == i; latched at start.
- dut_y  input  1  DUT output under test.
- stim  output  N_IN  current input vector; stim[N_IN-1] is MSB (A in A,B,C order).
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when the sweep ends.
- pass  output  1  high when err_count == 0; valid from done until the next start.
- err_count  output  N_IN+1  number of mismatching vectors in the last sweep.
- captured  output  2^N_IN  sampled dut_y per vector; bit i = Y observed at stim == i.

Behaviour:
- Reset (async, any state): state=IDLE; stim=0, busy=0, done=0, pass=0, err_count=0, captured=0; hold counter=0.
- FSM states are IDLE, HOLD, FIN.
- IDLE:
  - start=1 at edge k: latch tt_mask; clear err_count, captured and pass; stim=0; busy=1; go to HOLD at edge k+1.
  - start=0: stay in IDLE, outputs unchanged.
- HOLD:
  - Hold counter counts 0..HOLD_CYCLES-1.
  - At counter == HOLD_CYCLES-1: captured[stim] <= dut_y; if dut_y != mask[stim], err_count += 1.
  - At that same edge, if stim == 2^N_IN-1 go to FIN; else stim += 1 and counter = 0.
- FIN: done=1 for exactly one cycle; busy=0; pass = (err_count == 0), with err_count already including the last vector; return to IDLE. stim, captured and err_count hold their values.
- Latency: done is high during the cycle following edge k + 1 + 2^N_IN*HOLD_CYCLES. Defaults give k+33.
- start while busy or in FIN is ignored, with no restart.
- tt_mask changes after start have no effect on the current sweep.
- Counter widths: stim has no wrap; the terminal vector is detected explicitly. err_count cannot overflow because its maximum is 2^N_IN.
- HOLD_CYCLES=1: one vector per clock; sampling happens on the same edge stim advances.

Optional Feature:
- Macro: TT_SWEEP_STOP_ON_ERR_EN.
- Defined: the first mismatch ends the sweep. The FSM goes from HOLD to FIN on that sampling edge, stim freezes at the failing vector, err_count=1, pass=0, and captured bits above the failing index remain 0.
- Undefined: the full sweep always completes and every mismatch is counted.

Decomposition:
- Package tt_sweep_pkg holds:
  - the state enum typedef (IDLE, HOLD, FIN);
  - the localparam function num_vectors(n) = 1<<n;
  - the N_IN/HOLD_CYCLES range-check constants.
- One sub-module, tt_hold_timer, is the natural split: a HOLD_CYCLES down-counter with a load input and a terminal-count output.
- The checker FSM, capture and compare logic stay in the top module.

Test Plan:
- Defaults; DUT Y = A·B·C + A·B + A·C = A·(B+C) with A=stim[2], C=stim[0]; tt_mask=8'hE0; start at edge k -> done at k+33, pass=1, err_count=0, captured=8'hE0, stim=7.
- Same DUT, tt_mask=8'hE8 (vector 3 mismatches) -> pass=0, err_count=1, captured=8'hE0. With TT_SWEEP_STOP_ON_ERR_EN: done at k+17, stim=3.
- DUT Y tied 0, tt_mask=8'hFF -> err_count=8 (max, no overflow), pass=0, captured=0.
- Assert rst at edge k+10 mid-sweep -> all outputs 0 immediately. A start after reset release yields a clean full sweep (pass=1 with the first DUT).
- start pulsed again at k+5 during a sweep and tt_mask changed at k+6 -> ignored; result identical to the first scenario.
- N_IN=2, HOLD_CYCLES=1, DUT = XOR, tt_mask=4'h6 -> done at k+5, pass=1, captured=4'h6.
